// File: rtl/rx_pkg.sv
// Shared constants for the oversampling serial receiver: defaults, FSM encodings, vote helper.
package rx_pkg;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 128;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Receive byte FIFO: registered read data, registered empty/full, push is dropped when full.
module rx_fifo
  import rx_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [7:0]    r_data;
  logic          r_empty;
  logic          r_full;
  logic          w_do_push;
  logic          w_do_pop;

  // Fullness is judged on the current cycle, so a simultaneous read cannot make room for a push.
  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & ~r_empty;
  assign w_cnt_nxt = r_cnt + CW'(w_do_push) - CW'(w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_data   <= 8'h00;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_data   <= r_mem[r_rd_ptr];
      end
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == CW'(0));
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data  = r_data;
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/rx_core.sv
// Oversampling serial receiver with parity/framing checks and a receive FIFO.
// Define RX_MAJORITY_VOTE_EN to take each bit as a 3-sample majority around mid-bit.
module rx_core
  import rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_SampleSig_i,
  input  logic       Rx_i,
  input  logic       p_ParityEnable_i,
  input  logic       ParityMethod_i,
  input  logic       p_BigEnd_i,
  input  logic       n_re_i,
  output logic [7:0] data_o,
  output logic       p_empty_o,
  output logic       p_full_o,
  output logic       p_ParityErr_o,
  output logic       p_FrameErr_o,
  output logic       p_Overrun_o,
  input  logic       p_ErrClr_i
);

  localparam int unsigned TW   = $clog2(OVERSAMPLE);
  localparam int unsigned HALF = OVERSAMPLE / 2;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_rx_prev;
  logic               w_rx;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [TW-1:0]      r_tick;
  logic [2:0]         r_bitcnt;
  logic [7:0]         r_data;
  logic               r_par_en;
  logic               r_par_odd;
  logic               r_big_end;
  logic               r_par_bad;
  logic               r_s1;
  logic               w_bit;
  logic               w_decide;
  logic               w_start;
  logic               w_shift;
  logic               w_push;
  logic               w_set_perr;
  logic               w_set_ferr;
  logic               w_fifo_full;
  logic               w_pop;
  logic               r_perr;
  logic               r_ferr;
  logic               r_ovr;

  assign w_rx = r_sync2;

  // Every bit decision lands on tick HALF+1 of its window so both builds share one timeline.
  assign w_decide = p_SampleSig_i && (r_tick == TW'(HALF));

`ifdef RX_MAJORITY_VOTE_EN
  logic r_s0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b1;
    end else if (p_SampleSig_i && (r_tick == TW'(HALF - 2))) begin
      r_s0 <= w_rx;
    end
  end

  assign w_bit = maj3(r_s0, r_s1, w_rx);
`else
  assign w_bit = r_s1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_push      = 1'b0;
    w_set_perr  = 1'b0;
    w_set_ferr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rx_prev && !w_rx) begin
          w_start     = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_decide) begin
          w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_decide) begin
          w_shift = 1'b1;
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (w_decide) begin
          w_set_perr  = ((^r_data) ^ w_bit) != r_par_odd;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_decide) begin
          if (w_bit) begin
            w_push      = ~r_par_bad;
            w_state_nxt = ST_IDLE;
          end else begin
            w_set_ferr  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (w_rx) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_tick    <= '0;
      r_bitcnt  <= 3'd0;
      r_data    <= 8'h00;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_big_end <= 1'b0;
      r_par_bad <= 1'b0;
      r_s1      <= 1'b1;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sync1   <= Rx_i;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;

      if (w_start) begin
        r_tick <= '0;
      end else if (p_SampleSig_i) begin
        r_tick <= (r_tick == TW'(OVERSAMPLE - 1)) ? '0 : r_tick + TW'(1);
      end

      if (p_SampleSig_i && (r_tick == TW'(HALF - 1))) begin
        r_s1 <= w_rx;
      end

      // Configuration is frozen for the whole frame at the start edge.
      if (w_start) begin
        r_par_en  <= p_ParityEnable_i;
        r_par_odd <= ParityMethod_i;
        r_big_end <= p_BigEnd_i;
        r_bitcnt  <= 3'd0;
        r_par_bad <= 1'b0;
      end else if (w_set_perr) begin
        r_par_bad <= 1'b1;
      end

      if (w_shift) begin
        r_data   <= r_big_end ? {r_data[6:0], w_bit} : {w_bit, r_data[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      r_perr <= w_set_perr | (r_perr & ~p_ErrClr_i);
      r_ferr <= w_set_ferr | (r_ferr & ~p_ErrClr_i);
      r_ovr  <= (w_push & w_fifo_full) | (r_ovr & ~p_ErrClr_i);
    end
  end

  assign w_pop = ~n_re_i;

  rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_data),
    .i_pop   (w_pop),
    .o_data  (data_o),
    .o_empty (p_empty_o),
    .o_full  (w_fifo_full)
  );

  assign p_full_o      = w_fifo_full;
  assign p_ParityErr_o = r_perr;
  assign p_FrameErr_o  = r_ferr;
  assign p_Overrun_o   = r_ovr;

endmodule

// File: doc/rx_core.md
RX_CORE -- requirements
Module: rx_core

Interface
REQ-001 Parameter FIFO_DEPTH, default 128, number of received-byte entries buffered (power of two, 4..256).
REQ-002 Parameter OVERSAMPLE, default 16, p_SampleSig_i ticks per bit period (even, 8..16).
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 p_SampleSig_i  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-006 Rx_i  input  1  asynchronous serial line, idle high.
REQ-007 p_ParityEnable_i  input  1  1 = frame carries parity bit.
REQ-008 ParityMethod_i  input  1  0 = even, 1 = odd.
REQ-009 p_BigEnd_i  input  1  1 = MSB received first, 0 = LSB first.
REQ-010 n_re_i  input  1  active-low FIFO read strobe.
REQ-011 data_o  output  8  head byte returned by the last accepted read.
REQ-012 p_empty_o / p_full_o  output  1 each  FIFO empty / full.
REQ-013 p_ParityErr_o, p_FrameErr_o, p_Overrun_o  output  1 each  sticky error flags.
REQ-014 p_ErrClr_i  input  1  1 = clear all sticky flags.

Function
REQ-015 Rx_i SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-017 IDLE->START on synchronized high-to-low transition; tick counter cleared.
REQ-018 START: at tick OVERSAMPLE/2, sample 0 -> DATA, sample 1 -> IDLE (glitch, nothing recorded).
REQ-019 DATA: sample every OVERSAMPLE ticks; after 8 bits -> PARITY if p_ParityEnable_i, else STOP.
REQ-020 Bit placement: p_BigEnd_i=0 fills bit0 first; =1 fills bit7 first.
REQ-021 PARITY: one sample; error if XOR(data, sampled bit) != ParityMethod_i.
REQ-022 STOP: one sample; 1 -> frame good, ->IDLE same cycle; 0 -> p_FrameErr_o set, ->BREAK.
REQ-023 BREAK: remain until synchronized line is 1, then ->IDLE.
REQ-024 Byte SHALL be pushed to FIFO at the stop sample only if stop=1 and no parity error; otherwise it is discarded.
REQ-025 Parity or framing error SHALL set the matching sticky flag in the cycle after the offending sample.
REQ-026 Push while FIFO full (evaluated that cycle, even with a simultaneous read) SHALL drop the byte and set p_Overrun_o.
REQ-027 Read: n_re_i=0 and not empty -> data_o = head, pointer advances, visible the next cycle; read when empty is ignored and data_o holds.
REQ-028 Simultaneous push and read when not full: both SHALL take effect; occupancy unchanged.
REQ-029 p_ErrClr_i SHALL clear flags next cycle; a same-cycle new error SHALL win (flag stays 1).
REQ-030 Configuration inputs SHALL be sampled only in IDLE->START; mid-frame changes take effect on the next frame.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE, empty FIFO, data_o=0, p_empty_o=1, p_full_o=0, all error flags 0, synchronizer flops=1.
REQ-032 Reset mid-frame SHALL abandon the partial byte; reception restarts on the next falling edge after release.

Configuration
REQ-033 Macro RX_MAJORITY_VOTE_EN defined: each bit value = majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1; undefined: single sample at OVERSAMPLE/2. Timing of state transitions is identical in both builds.

Structure
REQ-034 FSM state encodings and default FIFO_DEPTH/OVERSAMPLE SHALL live in the shared package/header rx_pkg.
REQ-035 The FIFO SHALL be one sub-module, rx_fifo (pointers, count, full/empty); framing logic stays in rx_core.

Verification
REQ-036 8N1 LSB-first 0xA5, OVERSAMPLE=16 -> after stop, p_empty_o=0; read -> data_o=0xA5, no flags.
REQ-037 8E1 MSB-first 0x3C with wrong parity bit 1 -> byte discarded, p_ParityErr_o=1, p_empty_o stays 1.
REQ-038 Stop bit held 0 for 3 bit times, then 0x55 frame -> p_FrameErr_o=1, only 0x55 in FIFO.
REQ-039 Low glitch of 4 ticks on idle line -> FSM returns to IDLE, FIFO empty, no flags.
REQ-040 Send 129 bytes with depth 128 and no reads -> p_full_o=1, p_Overrun_o=1, first 128 bytes read back in order.
REQ-041 rst during DATA bit 4, then full 0x81 frame -> only 0x81 received; with RX_MAJORITY_VOTE_EN, a single-tick spike at mid-bit does not flip the sampled bit.
